psx_host: RTL
=============

Name: psx_host

Overview:
- Parametrised PlayStation controller host (successor to the fixed 0x01/0x42 poller).
- Runs one complete poll transaction per `start` request:
  - asserts ATT;
  - shifts the command bytes out LSB-first while capturing response bytes full-duplex;
  - waits for the controller ACK between bytes;
  - sizes the transfer from the returned controller ID.
- Runs on the system clock with a derived `psx_clk`.
- Adds ACK timeout, ID/mode detection and error reporting.

Parameters:
- CLK_DIV, 4: system clocks per psx_clk half-period (>=2).
- ATT_SETUP, 8: system clocks between ATT low and the first psx_clk falling edge.
- BYTE_GAP, 8: system clocks between ACK seen and the next byte.
- ACK_TIMEOUT, 256: system clocks allowed for ACK after a non-final byte.
- MAX_DATA_BYTES, 6: capacity of the payload buffer (bytes after 0x5A).
- POLL_CMD, 8'h42: second command byte.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a poll; sampled only in IDLE
- busy  out  1  high from start accept until done
- done  out  1  one-cycle pulse at end of transaction
- timeout_err  out  1  valid with done: ACK missing
- id_err  out  1  valid with done: bad ID or bad 0x5A byte
- ctrl_id  out  8  ID byte (response to byte 1)
- rx_data  out  8*MAX_DATA_BYTES  payload; byte k at [8k+7:8k]
- rx_count  out  $clog2(MAX_DATA_BYTES+1)  payload bytes captured
- psx_data  in  1  controller DATA
- psx_ack_n  in  1  controller ACK, active-low pulse
- psx_clk  out  1  controller clock, idle high
- psx_cmd  out  1  controller CMD, idle high
- psx_att_n  out  1  controller ATT, active-low

Behaviour:
- **Reset values:** psx_clk=1, psx_cmd=1, psx_att_n=1, busy=0, done=0, both errors 0, ctrl_id=0, rx_data=0, rx_count=0.
- **Reset mid-transaction:** all outputs return to reset values immediately. No done pulse.
- **Input synchronisers:** psx_data and psx_ack_n each pass through 2-flop synchronisers.
- **ACK detection:** ACK = falling edge of the synchronised ack_n.
- **Byte indices (0-based):**
  - byte 0: cmd 0x01;
  - byte 1: cmd POLL_CMD, response = ID;
  - byte 2: cmd 0x00, response must be 0x5A;
  - bytes 3..: cmd 0x00, response = payload.
- **Bit timing:**
  - psx_clk falls, and psx_cmd updates on that fall (LSB first).
  - After CLK_DIV clocks psx_clk rises; the synchronised data bit is captured CLK_DIV clocks after the rise, immediately before the next fall.
  - Response bytes are assembled LSB-first.
- **States:**
  - IDLE: start=1 -> ATT_SETUP; busy=1, att_n=0, errors cleared, rx_count=0.
  - ATT_SETUP: ATT_SETUP clocks -> SHIFT.
  - SHIFT: 8 bits -> store byte. Final byte -> RELEASE; otherwise -> ACK_WAIT. psx_clk is left high after bit 7.
  - ACK_WAIT: ACK seen -> GAP. Counter reaches ACK_TIMEOUT -> RELEASE with timeout_err=1.
  - GAP: BYTE_GAP clocks -> SHIFT.
  - RELEASE: att_n=1, cmd=1; one clock -> IDLE, done=1, busy=0.
- **Transfer length:**
  - Payload length N = 2*ID[3:0], with ID[3:0]==0 meaning 32.
  - Final byte index = 2+N.
- **ID error:** set id_err and make the current byte final (-> RELEASE, no ACK wait) when any of these hold:
  - ID==8'hFF (no controller);
  - N>MAX_DATA_BYTES;
  - byte 2 response != 8'h5A.
- **Capture updates:** ctrl_id and rx_data bytes update as each byte completes; rx_count increments per payload byte.
- **Start while busy:** ignored. Start in the same cycle as done's IDLE re-entry is accepted on the next cycle.
- **ACK during SHIFT or GAP:** ignored. An ACK before ACK_WAIT is not remembered.

Decomposition:
- Shared package `psx_pkg`:
  - constants PSX_START=8'h01, PSX_POLL=8'h42, PSX_READY=8'h5A, PSX_NO_CTRL=8'hFF;
  - state enum;
  - function id_to_len (ID -> payload bytes).
- One sub-module: `psx_byte_shifter`, an 8-bit full-duplex shifter with clock divider. Interface: go, tx_byte, rx_byte, byte_done, psx_clk/psx_cmd drive.
- Top-level FSM: handles ATT, ACK and sequencing.

Test Plan:
- **Digital pad** (CLK_DIV=4), ID 0x41, responses 5A FF FE, ACK after each non-final byte -> 5 bytes on CMD: 01 42 00 00 00. Then done with ctrl_id=0x41, rx_count=2, rx_data[15:0]=16'hFEFF, no errors.
- **Analog pad**, ID 0x73, payload 11 22 33 44 55 66 -> rx_count=6, rx_data=48'h665544332211, 9 bytes clocked, ACK absent after the last byte without error.
- **No ACK after byte 1** -> psx_att_n high ACK_TIMEOUT+1 clocks later, done with timeout_err=1, rx_count=0.
- **Bad ID or bad ready byte:**
  - ID 0xFF -> done after byte 1, id_err=1, only 2 bytes clocked.
  - ID 0x79 (N=18 > 6) -> same.
  - ID 0x41 with byte 2 = 0x00 -> id_err=1 after 3 bytes.
- **Reset and restart:** rst_n low mid-byte 3 -> outputs at reset values in the same cycle, no done. A subsequent start runs a clean transaction. Start pulsed while busy -> exactly one transaction.
- **Bit order check:** byte 1 CMD waveform = 0,1,0,0,0,0,1,0 on successive falls; psx_clk idle high between bytes and while ATT is high.

Source files
------------

// File: rtl/psx_pkg.sv
// Shared constants, FSM state type and ID decoding for the PlayStation controller host.
package psx_pkg;

  localparam logic [7:0] PSX_START   = 8'h01;
  localparam logic [7:0] PSX_POLL    = 8'h42;
  localparam logic [7:0] PSX_READY   = 8'h5A;
  localparam logic [7:0] PSX_NO_CTRL = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ATT_SETUP,
    ST_SHIFT,
    ST_ACK_WAIT,
    ST_GAP,
    ST_RELEASE
  } psx_state_t;

  // Payload length is twice the low ID nibble; a zero nibble means 32 bytes.
  function automatic logic [5:0] id_to_len(input logic [7:0] id);
    return (id[3:0] == 4'd0) ? 6'd32 : {1'b0, id[3:0], 1'b0};
  endfunction

endpackage

// File: rtl/psx_byte_shifter.sv
// One full-duplex byte on the controller bus: psx_clk falls with each CMD bit (LSB first),
// DATA is sampled just before the following fall, and psx_clk is left high after bit 7.
module psx_byte_shifter
  import psx_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic [7:0] tx_byte,
  input  logic       data_in,
  output logic [7:0] rx_byte,
  output logic       byte_done,
  output logic       psx_clk,
  output logic       psx_cmd
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);

  logic             active_q, active_d;
  logic             clk_q, clk_d;
  logic             cmd_q, cmd_d;
  logic             done_q, done_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;

  always_comb begin
    active_d = active_q;
    clk_d    = clk_q;
    cmd_d    = cmd_q;
    done_d   = 1'b0;
    div_d    = div_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    if (!active_q) begin
      if (go) begin
        active_d = 1'b1;
        clk_d    = 1'b0;
        cmd_d    = tx_byte[0];
        tx_d     = tx_byte;
        bit_d    = 3'd0;
        div_d    = '0;
      end
    end else if (div_q != DIV_W'(CLK_DIV - 1)) begin
      div_d = div_q + DIV_W'(1);
    end else begin
      div_d = '0;
      if (!clk_q) begin
        clk_d = 1'b1;
      end else begin
        rx_d = {data_in, rx_q[7:1]};
        if (bit_q == 3'd7) begin
          active_d = 1'b0;
          done_d   = 1'b1;
          cmd_d    = 1'b1;
        end else begin
          clk_d = 1'b0;
          bit_d = bit_q + 3'd1;
          cmd_d = tx_q[bit_q + 3'd1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      clk_q    <= 1'b1;
      cmd_q    <= 1'b1;
      done_q   <= 1'b0;
      div_q    <= '0;
      bit_q    <= 3'd0;
      tx_q     <= 8'd0;
      rx_q     <= 8'd0;
    end else begin
      active_q <= active_d;
      clk_q    <= clk_d;
      cmd_q    <= cmd_d;
      done_q   <= done_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
    end
  end

  assign rx_byte   = rx_q;
  assign byte_done = done_q;
  assign psx_clk   = clk_q;
  assign psx_cmd   = cmd_q;

endmodule

// File: rtl/psx_host.sv
// PlayStation controller host: one ATT-framed poll per start, sized from the returned ID,
// with ACK timeout and ID / ready-byte error reporting.
module psx_host
  import psx_pkg::*;
#(
  parameter int         CLK_DIV        = 4,
  parameter int         ATT_SETUP      = 8,
  parameter int         BYTE_GAP       = 8,
  parameter int         ACK_TIMEOUT    = 256,
  parameter int         MAX_DATA_BYTES = 6,
  parameter logic [7:0] POLL_CMD       = PSX_POLL
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                timeout_err,
  output logic                                id_err,
  output logic [7:0]                          ctrl_id,
  output logic [8*MAX_DATA_BYTES-1:0]         rx_data,
  output logic [$clog2(MAX_DATA_BYTES+1)-1:0] rx_count,
  input  logic                                psx_data,
  input  logic                                psx_ack_n,
  output logic                                psx_clk,
  output logic                                psx_cmd,
  output logic                                psx_att_n
);

  localparam int RCW     = $clog2(MAX_DATA_BYTES + 1);
  localparam int CNT_MAX = (ACK_TIMEOUT > ATT_SETUP) ?
                           ((ACK_TIMEOUT > BYTE_GAP) ? ACK_TIMEOUT : BYTE_GAP) :
                           ((ATT_SETUP > BYTE_GAP) ? ATT_SETUP : BYTE_GAP);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  psx_state_t                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [5:0]                idx_q, idx_d;
  logic [5:0]                last_idx_q, last_idx_d;
  logic                      busy_q, busy_d, done_q, done_d, att_n_q, att_n_d;
  logic                      terr_q, terr_d, iderr_q, iderr_d;
  logic [7:0]                ctrl_id_q, ctrl_id_d;
  logic [8*MAX_DATA_BYTES-1:0] rx_data_q, rx_data_d;
  logic [RCW-1:0]            rx_count_q, rx_count_d;
  logic                      data_s1_q, data_s2_q, ack_s1_q, ack_s2_q, ack_s3_q;

  logic       sh_go, sh_done, ack_fall, bad_byte, last_byte;
  logic [7:0] sh_tx, sh_rx;
  logic [5:0] len;

  assign ack_fall = ack_s3_q & ~ack_s2_q;
  assign sh_tx    = (idx_q == 6'd0) ? PSX_START : (idx_q == 6'd1) ? POLL_CMD : 8'h00;

  psx_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (sh_go),
    .tx_byte  (sh_tx),
    .data_in  (data_s2_q),
    .rx_byte  (sh_rx),
    .byte_done(sh_done),
    .psx_clk  (psx_clk),
    .psx_cmd  (psx_cmd)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    att_n_d    = att_n_q;
    terr_d     = terr_q;
    iderr_d    = iderr_q;
    ctrl_id_d  = ctrl_id_q;
    rx_data_d  = rx_data_q;
    rx_count_d = rx_count_q;
    sh_go      = 1'b0;
    bad_byte   = 1'b0;
    last_byte  = 1'b0;
    len        = id_to_len(sh_rx);
    case (state_q)
      ST_IDLE: if (start) begin
        state_d    = ST_ATT_SETUP;
        busy_d     = 1'b1;
        att_n_d    = 1'b0;
        terr_d     = 1'b0;
        iderr_d    = 1'b0;
        rx_count_d = '0;
        cnt_d      = '0;
        idx_d      = 6'd0;
      end
      ST_ATT_SETUP, ST_GAP: begin
        if (cnt_q == CNT_W'(((state_q == ST_GAP) ? BYTE_GAP : ATT_SETUP) - 1)) begin
          sh_go   = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SHIFT: if (sh_done) begin
        if (idx_q == 6'd1) begin
          ctrl_id_d  = sh_rx;
          last_idx_d = 6'd2 + len;
          bad_byte   = (sh_rx == PSX_NO_CTRL) || (int'(len) > MAX_DATA_BYTES);
        end else if (idx_q == 6'd2) begin
          bad_byte = (sh_rx != PSX_READY);
        end else if (idx_q >= 6'd3) begin
          for (int k = 0; k < MAX_DATA_BYTES; k++)
            if (idx_q == 6'(k + 3)) rx_data_d[8*k +: 8] = sh_rx;
          rx_count_d = rx_count_q + RCW'(1);
        end
        last_byte = (idx_q >= 6'd2) && (idx_q == last_idx_q);
        if (bad_byte || last_byte) begin
          iderr_d = bad_byte;
          att_n_d = 1'b1;
          state_d = ST_RELEASE;
        end else begin
          cnt_d   = '0;
          idx_d   = idx_q + 6'd1;
          state_d = ST_ACK_WAIT;
        end
      end
      ST_ACK_WAIT: begin
        if (ack_fall) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT)) begin
          terr_d  = 1'b1;
          att_n_d = 1'b1;
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= 6'd0;
      last_idx_q <= 6'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      att_n_q    <= 1'b1;
      terr_q     <= 1'b0;
      iderr_q    <= 1'b0;
      ctrl_id_q  <= 8'd0;
      rx_data_q  <= '0;
      rx_count_q <= '0;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
      ack_s1_q   <= 1'b1;
      ack_s2_q   <= 1'b1;
      ack_s3_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      att_n_q    <= att_n_d;
      terr_q     <= terr_d;
      iderr_q    <= iderr_d;
      ctrl_id_q  <= ctrl_id_d;
      rx_data_q  <= rx_data_d;
      rx_count_q <= rx_count_d;
      data_s1_q  <= psx_data;
      data_s2_q  <= data_s1_q;
      ack_s1_q   <= psx_ack_n;
      ack_s2_q   <= ack_s1_q;
      ack_s3_q   <= ack_s2_q;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign id_err      = iderr_q;
  assign ctrl_id     = ctrl_id_q;
  assign rx_data     = rx_data_q;
  assign rx_count    = rx_count_q;
  assign psx_att_n   = att_n_q;

endmodule
